// File: rtl/ram_io_responder.sv
// Data-bus responder: word-organised RAM with byte/halfword lanes and sign/zero
// extension, plus an IO page with LEDs, synchronised switches, a timer and sticky status.
module ram_io_responder #(
    parameter int          RAM_AW  = 10,
    parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_dat,
    input  logic        wr,
    input  logic [2:0]  rw_type,
    output logic [31:0] rd_dat,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        RW_B  = 3'b000,
        RW_H  = 3'b001,
        RW_W  = 3'b010,
        RW_BU = 3'b100,
        RW_HU = 3'b101
    } rw_t;

    localparam int          RAM_WORDS = 2 ** RAM_AW;
    localparam logic [11:0] OFF_LED   = 12'h000;
    localparam logic [11:0] OFF_SW    = 12'h004;
    localparam logic [11:0] OFF_CNT   = 12'h008;
    localparam logic [11:0] OFF_CMP   = 12'h00C;
    localparam logic [11:0] OFF_STAT  = 12'h010;

    logic [31:0]       mem [RAM_WORDS];
    logic [RAM_AW-1:0] word_idx;
    logic [31:0]       ram_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ram_rd;
    logic [31:0]       io_rd;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              is_byte, is_half, is_word, type_ok, misaligned;
    logic              in_ram, in_io, ram_we, io_we, stat_we;
    logic [11:0]       io_off;
    logic [15:0]       sw_meta, sw_sync;
    logic [31:0]       timer_cnt, timer_cmp;

    assign word_idx = addr[RAM_AW+1:2];
    assign io_off   = addr[11:0];
    assign in_ram   = (addr[31:RAM_AW+2] == '0);
    assign in_io    = (addr[31:12] == IO_BASE[31:12]);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        is_byte    = (rw_type == RW_B) || (rw_type == RW_BU);
        is_half    = (rw_type == RW_H) || (rw_type == RW_HU);
        is_word    = (rw_type == RW_W);
        type_ok    = is_byte || is_half || is_word;
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end

    assign ram_we  = wr && in_ram && type_ok && !misaligned;
    assign io_we   = wr && in_io && is_word && !misaligned;
    assign stat_we = io_we && (io_off == OFF_STAT);

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        be    = 4'b0000;
        wdata = wr_dat;
        if (is_byte) begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{wr_dat[7:0]}};
        end else if (is_half) begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wr_dat[15:0]}};
        end else if (is_word) begin
            be    = 4'b1111;
        end
    end

    // NOTE: the RAM array has no reset branch; clearing it would turn block RAM into flops.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign ram_word = mem[word_idx];
    assign rd_byte  = ram_word[8*addr[1:0] +: 8];
    assign rd_half  = addr[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        ram_rd = '0;
        case (rw_type)
            RW_B:    ram_rd = {{24{rd_byte[7]}}, rd_byte};
            RW_BU:   ram_rd = {24'h0, rd_byte};
            RW_H:    ram_rd = {{16{rd_half[15]}}, rd_half};
            RW_HU:   ram_rd = {16'h0, rd_half};
            RW_W:    ram_rd = ram_word;
            default: ram_rd = '0;
        endcase
    end

    always_comb begin
        io_rd = '0;
        if (is_word) begin
            case (io_off)
                OFF_LED:  io_rd = {16'h0, led};
                OFF_SW:   io_rd = {16'h0, sw_sync};
                OFF_CNT:  io_rd = timer_cnt;
                OFF_CMP:  io_rd = timer_cmp;
                OFF_STAT: io_rd = {30'h0, misalign_err, timer_irq};
                default:  io_rd = '0;
            endcase
        end
    end

    always_comb begin
        rd_dat = '0;
        if (!misaligned) begin
            if (in_ram)     rd_dat = ram_rd;
            else if (in_io) rd_dat = io_rd;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led          <= '0;
            sw_meta      <= '0;
            sw_sync      <= '0;
            timer_cnt    <= '0;
            timer_cmp    <= 32'hFFFF_FFFF;
            timer_irq    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (io_we && (io_off == OFF_LED)) led <= wr_dat[15:0];
            if (io_we && (io_off == OFF_CMP)) timer_cmp <= wr_dat;
            timer_cnt <= (io_we && (io_off == OFF_CNT)) ? wr_dat : timer_cnt + 32'd1;
            // Set terms are OR-ed after the clear so a simultaneous match beats W1C.
            timer_irq    <= (timer_cnt == timer_cmp) | (timer_irq & ~(stat_we & wr_dat[0]));
            misalign_err <= misaligned | (misalign_err & ~(stat_we & wr_dat[1]));
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus a randomized
// RAM/unmapped traffic run checked against a byte-array reference model.
module tb_ram_io_responder;

    localparam logic [31:0] IO = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_dat;
    logic        wr;
    logic [2:0]  rw_type;
    logic [31:0] rd_dat;
    logic [15:0] sw;
    logic [15:0] led;
    logic        timer_irq;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    byte unsigned mdl_mem [4096];
    logic         mdl_err;

    ram_io_responder dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wr_dat       (wr_dat),
        .wr           (wr),
        .rw_type      (rw_type),
        .rd_dat       (rd_dat),
        .sw           (sw),
        .led          (led),
        .timer_irq    (timer_irq),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr    = 32'h0;
        rw_type = 3'b010;
        wr      = 1'b0;
        wr_dat  = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        addr    = a;
        wr_dat  = d;
        rw_type = t;
        wr      = 1'b1;
        step();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] t, output logic [31:0] v);
        addr    = a;
        rw_type = t;
        wr      = 1'b0;
        #1;
        v = rd_dat;
    endtask

    function automatic logic is_mis(input logic [31:0] a, input logic [2:0] t);
        return ((t == 3'b001 || t == 3'b101) && a[0]) || (t == 3'b010 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] t);
        logic [7:0]  b;
        logic [15:0] h;
        if (is_mis(a, t) || a >= 32'd4096) return 32'h0;
        b = mdl_mem[a];
        h = {mdl_mem[a + 1], mdl_mem[a]};
        case (t)
            3'b000:  return 32'(signed'(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'(signed'(h));
            3'b101:  return {16'h0, h};
            3'b010:  return {mdl_mem[a + 3], mdl_mem[a + 2], h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        if (is_mis(a, t) || a >= 32'd4096 || t > 3'b010) return;
        mdl_mem[a] = d[7:0];
        if (t != 3'b000) mdl_mem[a + 1] = d[15:8];
        if (t == 3'b010) begin
            mdl_mem[a + 2] = d[23:16];
            mdl_mem[a + 3] = d[31:24];
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        sw  = 16'h0;
        idle();
        #2;
        checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0000", led); end
        checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
        rd(IO + 32'h8, 3'b010, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=00000000", v); end
        rd(IO + 32'hC, 3'b010, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", v); end
        idle();
        #4 rst = 1'b0;
        step();
    endtask

    task automatic test_ram_lanes();
        logic [31:0] v;
        do_write(32'h10, 32'h8000_00FF, 3'b010);
        rd(32'h10, 3'b010, v);
        checks++; if (v !== 32'h8000_00FF) begin failures++; $display("FAIL lw got=%h exp=800000ff", v); end
        rd(32'h10, 3'b000, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb got=%h exp=ffffffff", v); end
        rd(32'h10, 3'b100, v);
        checks++; if (v !== 32'h0000_00FF) begin failures++; $display("FAIL lbu got=%h exp=000000ff", v); end
        rd(32'h12, 3'b001, v);
        checks++; if (v !== 32'hFFFF_8000) begin failures++; $display("FAIL lh got=%h exp=ffff8000", v); end
        rd(32'h12, 3'b101, v);
        checks++; if (v !== 32'h0000_8000) begin failures++; $display("FAIL lhu got=%h exp=00008000", v); end
        do_write(32'h10, 32'h1122_3344, 3'b010);
        do_write(32'h11, 32'h0000_005A, 3'b000);
        rd(32'h10, 3'b010, v);
        checks++; if (v !== 32'h1122_5A44) begin failures++; $display("FAIL sb_merge got=%h exp=11225a44", v); end
        do_write(32'h12, 32'h0000_BEEF, 3'b001);
        rd(32'h10, 3'b010, v);
        checks++; if (v !== 32'hBEEF_5A44) begin failures++; $display("FAIL sh_merge got=%h exp=beef5a44", v); end
        idle();
    endtask

    task automatic test_misalign();
        logic [31:0] v;
        do_write(32'h14, 32'hCAFE_F00D, 3'b010);
        addr = 32'h16; wr_dat = 32'h1234_5678; rw_type = 3'b010; wr = 1'b1;
        #1;
        checks++; if (rd_dat !== 32'h0) begin failures++; $display("FAIL mis_rd got=%h exp=00000000", rd_dat); end
        step();
        idle();
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", misalign_err); end
        rd(32'h14, 3'b010, v);
        checks++; if (v !== 32'hCAFE_F00D) begin failures++; $display("FAIL mis_nowrite got=%h exp=cafef00d", v); end
        do_write(IO + 32'h10, 32'h2, 3'b010);
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_w1c got=%b exp=0", misalign_err); end
        addr = 32'h14; wr_dat = 32'hFFFF_FFFF; rw_type = 3'b011; wr = 1'b1;
        #1;
        checks++; if (rd_dat !== 32'h0) begin failures++; $display("FAIL badtype_rd got=%h exp=00000000", rd_dat); end
        step();
        idle();
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL badtype_err got=%b exp=0", misalign_err); end
        rd(32'h14, 3'b010, v);
        checks++; if (v !== 32'hCAFE_F00D) begin failures++; $display("FAIL badtype_nowrite got=%h exp=cafef00d", v); end
        do_write(32'h0010_0000, 32'h5555_5555, 3'b010);
        rd(32'h0010_0000, 3'b010, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=00000000", v); end
        idle();
    endtask

    task automatic test_led_sw();
        logic [31:0] v;
        do_write(IO, 32'hABCD_1234, 3'b010);
        checks++; if (led !== 16'h1234) begin failures++; $display("FAIL led_out got=%h exp=1234", led); end
        rd(IO, 3'b010, v);
        checks++; if (v !== 32'h0000_1234) begin failures++; $display("FAIL led_rd got=%h exp=00001234", v); end
        do_write(IO, 32'h0000_00FF, 3'b000);
        checks++; if (led !== 16'h1234) begin failures++; $display("FAIL led_sb got=%h exp=1234", led); end
        rd(IO, 3'b000, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL io_lb got=%h exp=00000000", v); end
        sw = 16'h00F0;
        step();
        rd(IO + 32'h4, 3'b010, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL sw_1edge got=%h exp=00000000", v); end
        step();
        rd(IO + 32'h4, 3'b010, v);
        checks++; if (v !== 32'h0000_00F0) begin failures++; $display("FAIL sw_2edge got=%h exp=000000f0", v); end
        idle();
    endtask

    task automatic test_timer();
        logic [31:0] v;
        do_write(IO + 32'h10, 32'h1, 3'b010);
        do_write(IO + 32'hC, 32'd5, 3'b010);
        do_write(IO + 32'h8, 32'd0, 3'b010);
        for (int k = 0; k < 9; k++) begin
            rd(IO + 32'h8, 3'b010, v);
            checks++; if (v !== 32'(k)) begin failures++; $display("FAIL cnt_%0d got=%h exp=%h", k, v, 32'(k)); end
            checks++; if (timer_irq !== (k >= 6)) begin failures++; $display("FAIL irq_%0d got=%b exp=%b", k, timer_irq, k >= 6); end
            step();
        end
        do_write(IO + 32'h8, 32'd20, 3'b010);
        do_write(IO + 32'h10, 32'h1, 3'b010);
        do_write(IO + 32'hC, 32'd23, 3'b010);
        checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", timer_irq); end
        step();
        do_write(IO + 32'h10, 32'h1, 3'b010);
        checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", timer_irq); end
        do_write(IO + 32'h10, 32'h1, 3'b010);
        checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_write(32'h20, 32'h0102_0304, 3'b010);
        addr = 32'h20; wr_dat = 32'hA0B0_C0D0; rw_type = 3'b010; wr = 1'b1;
        #1;
        checks++; if (rd_dat !== 32'h0102_0304) begin failures++; $display("FAIL rw_same_old got=%h exp=01020304", rd_dat); end
        step();
        rd(32'h20, 3'b010, v);
        checks++; if (v !== 32'hA0B0_C0D0) begin failures++; $display("FAIL rw_same_new got=%h exp=a0b0c0d0", v); end
        idle();
    endtask

    task automatic test_random();
        logic [2:0]  types [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        logic [31:0] a, d, exp;
        logic [2:0]  t;
        logic        w;
        do_write(IO + 32'h10, 32'h2, 3'b010);
        mdl_err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            do_write(32'(4 * i), d, 3'b010);
            mdl_store(32'(4 * i), d, 3'b010);
        end
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h0010_0000 + $urandom_range(0, 255) : $urandom_range(0, 255);
            t = types[$urandom_range(0, 6)];
            w = (t == 3'b100 || t == 3'b101) ? 1'b0 : 1'($urandom_range(0, 1));
            d = $urandom;
            addr = a; rw_type = t; wr = w; wr_dat = d;
            #1;
            exp = mdl_load(a, t);
            checks++; if (rd_dat !== exp) begin failures++; $display("FAIL rand_rd_%0d a=%h t=%0d got=%h exp=%h", i, a, t, rd_dat, exp); end
            step();
            if (w) mdl_store(a, d, t);
            mdl_err = mdl_err | is_mis(a, t);
            checks++; if (misalign_err !== mdl_err) begin failures++; $display("FAIL rand_err_%0d got=%b exp=%b", i, misalign_err, mdl_err); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        do_write(IO, 32'h0000_1234, 3'b010);
        do_write(IO + 32'hC, 32'd99, 3'b010);
        do_write(IO + 32'h8, 32'd99, 3'b010);
        step();
        rd(IO + 32'h8, 3'b010, v);
        checks++; if (v !== 32'd100 || timer_irq !== 1'b1) begin failures++; $display("FAIL prerst cnt=%h irq=%b exp cnt=00000064 irq=1", v, timer_irq); end
        #1 rst = 1'b1;
        #1;
        checks++; if (led !== 16'h0) begin failures++; $display("FAIL mrst_led got=%h exp=0000", led); end
        checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL mrst_irq got=%b exp=0", timer_irq); end
        rd(IO + 32'h8, 3'b010, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL mrst_cnt got=%h exp=00000000", v); end
        rd(IO + 32'hC, 3'b010, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mrst_cmp got=%h exp=ffffffff", v); end
        rd(32'h10, 3'b010, v);
        checks++; if (v !== 32'hBEEF_5A44) begin failures++; $display("FAIL mrst_ram got=%h exp=beef5a44", v); end
        idle();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_misalign();
        test_led_sw();
        test_timer();
        test_back_to_back();
        test_random();
        do_write(32'h10, 32'hBEEF_5A44, 3'b010);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
Memory-side responder for the core's data bus: it accepts address, write data, write enable and load/store type from the core, and returns read data. It contains a word-organised data RAM with byte/halfword lane handling and sign/zero extension. It also holds a memory-mapped IO page with an LED register, a synchronised switch input, a free-running timer with compare interrupt, and a sticky status register. It sits between the core and board IO and replaces ad-hoc RAM/IO glue.

Parameters:
RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words at byte addresses 0 .. 4*2^RAM_AW-1.
IO_BASE, 32'hFFFF_F000, base of the 4 KiB IO page; matched on addr[31:12].

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
addr  input  32  byte address from core ALU result.
wr_dat  input  32  store data (rs2 value, unshifted).
wr  input  1  write enable; store commits on the rising edge while high.
rw_type  input  3  funct3 access type: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
rd_dat  output  32  load data, combinational from current addr/rw_type.
sw  input  16  raw board switches, asynchronous.
led  output  16  LED register value.
timer_irq  output  1  STATUS bit0 (sticky timer match).
misalign_err  output  1  STATUS bit1 (sticky misaligned access).

Behaviour:
- Reset (async): led=0, TIMER_CNT=0, TIMER_CMP=32'hFFFF_FFFF, timer_irq=0, misalign_err=0, switch synchroniser=0. RAM contents are not reset.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Write suppressed; rd_dat=0.
  - Any misaligned access (read or write), in any region, sets misalign_err at the next edge.
- Invalid rw_type (011, 110, 111): rd_dat=0; writes dropped; no error.
- RAM region (addr < 4*2^RAM_AW):
  - Word index addr[RAM_AW+1:2].
  - sb writes wr_dat[7:0] to the lane addr[1:0]. sh writes wr_dat[15:0] to the lane addr[1]. sw writes the full word. Other bytes are unchanged.
  - Loads are combinational: select lane, sign-extend (000/001) or zero-extend (100/101).
  - Read and write in the same cycle: rd_dat shows the pre-edge contents; the new data is visible the following cycle.
- IO region (addr[31:12]==IO_BASE[31:12]):
  - Only word accesses (010) are honoured; other types read 0 and drop writes.
  - Offsets (addr[11:0]):
    - 0x000 LED: RW, bits[15:0]; reads zero-extended.
    - 0x004 SW: RO; 2-flop synchroniser, so an input change is readable after 2 edges.
    - 0x008 TIMER_CNT: RW; +1 every cycle, wraps FFFF_FFFF->0. A write loads wr_dat and wins over the increment.
    - 0x00C TIMER_CMP: RW.
    - 0x010 STATUS: bit0 timer_irq, bit1 misalign_err, others read 0. Write-1-to-clear per bit.
  - Other IO offsets read 0; writes dropped.
- Timer match: timer_irq sets at the edge where the pre-edge TIMER_CNT==TIMER_CMP. This includes the cycle TIMER_CNT is being written.
- Simultaneous set and W1C of the same STATUS bit: set wins.
- Unmapped addresses outside RAM and IO: read 0, writes dropped, no error.
- Write latency is 0 cycles (commit at edge). Read latency is combinational (same cycle).

Test Plan:
- sw 0x8000_00FF to RAM addr 0x10, then lw 0x10 -> rd_dat=0x8000_00FF; lb 0x10 -> 0xFFFF_FFFF (byte 0x00 at 0x13? no: byte@0x10=0xFF) sign-extended; lbu 0x10 -> 0x0000_00FF; lh 0x12 -> 0xFFFF_8000; lhu 0x12 -> 0x0000_8000.
- sb 0x5A to addr 0x11 over word 0x1122_3344 -> lw 0x10 returns 0x1122_5A44; sh 0xBEEF to 0x12 -> 0xBEEF_5A44.
- sw to 0x0000_0016 (misaligned): RAM word 0x14 unchanged, rd_dat=0, misalign_err=1 next cycle; sw 0x2 to IO_BASE+0x10 -> misalign_err=0.
- Write TIMER_CMP=5, write TIMER_CNT=0: timer_irq rises on the edge after CNT reads 5. Then W1C in the same cycle as a new match -> timer_irq stays 1.
- sw 0xABCD_1234 to IO_BASE+0x000 -> led=0x1234, lw reads 0x0000_1234; sb to the LED address -> led unchanged. sw=0x00F0 -> SW register reads 0x0000_00F0 two edges later.
- Assert rst mid-operation with led=0x1234, timer_irq=1, CNT=100 -> immediately led=0, timer_irq=0, CNT=0, CMP=0xFFFF_FFFF; RAM word written earlier still reads its old value.
